// File: rtl/t05_least_pair_finder_if.sv
// Bundle for the least-pair finder: scan control, the single-outstanding read
// port, and the registered result outputs.
`timescale 1ns/1ps
interface t05_least_pair_finder_if #(
  parameter int CNT_W  = 64,
  parameter int LEAF_N = 256,
  parameter int NODE_N = 128
);
  localparam int AW  = $clog2(LEAF_N + NODE_N);
  localparam int IW  = $clog2(LEAF_N) + 1;
  localparam int NLW = $clog2(NODE_N) + 1;

  logic             start;
  logic [NLW-1:0]   node_limit;
  logic             rd_req;
  logic [AW-1:0]    rd_addr;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic [IW-1:0]    least1;
  logic [IW-1:0]    least2;
  logic [CNT_W-1:0] val1;
  logic [CNT_W-1:0] val2;
  logic [CNT_W:0]   sum;
  logic [1:0]       found;
  logic             busy;
  logic             done;

  // master = the finder, which issues reads and publishes results
  modport master (
    input  start, node_limit, rd_valid, rd_data,
    output rd_req, rd_addr, least1, least2, val1, val2, sum, found, busy, done
  );

  modport slave (
    output start, node_limit, rd_valid, rd_data,
    input  rd_req, rd_addr, least1, least2, val1, val2, sum, found, busy, done
  );
endinterface

// File: rtl/t05_least_pair_finder.sv
// Scans leaf then internal-node weights and keeps the two smallest nonzero
// entries; earlier-scanned entries win ties.
`timescale 1ns/1ps
module t05_least_pair_finder #(
  parameter int CNT_W  = 64,
  parameter int LEAF_N = 256,
  parameter int NODE_N = 128
) (
  input  logic clk,
  input  logic rst,
  t05_least_pair_finder_if.master bus
);
  localparam int AW  = $clog2(LEAF_N + NODE_N);
  localparam int IW  = $clog2(LEAF_N) + 1;
  localparam int NLW = $clog2(NODE_N) + 1;

  // state | meaning
  // IDLE  | waiting for start, results held
  // REQ   | rd_req pulse for current addr
  // WAIT  | waiting for rd_valid, then compare
  // DONE  | done pulse, results published
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state;
  logic [AW-1:0]    addr;
  logic [AW-1:0]    last_addr;
  logic [IW-1:0]    w_least1, w_least2;
  logic [CNT_W-1:0] w_val1, w_val2;
  logic [1:0]       w_found;

  logic [NLW-1:0]   eff_limit;
  logic [IW-1:0]    entry_idx;
  logic [IW-1:0]    nxt_least1, nxt_least2;
  logic [CNT_W-1:0] nxt_val1, nxt_val2;
  logic [1:0]       nxt_found;
  logic [CNT_W:0]   nxt_sum;

  assign eff_limit = (bus.node_limit > NLW'(NODE_N)) ? NLW'(NODE_N) : bus.node_limit;
  assign entry_idx = {addr >= AW'(LEAF_N), addr[IW-2:0]};

  // Empty slots are tested via found rather than by value, so an all-ones
  // weight still registers as a real entry.
  always_comb begin
    nxt_least1 = w_least1;
    nxt_least2 = w_least2;
    nxt_val1   = w_val1;
    nxt_val2   = w_val2;
    nxt_found  = w_found;
    if (bus.rd_data != '0) begin
      if (w_found == 2'd0 || bus.rd_data < w_val1) begin
        nxt_least2 = w_least1;
        nxt_val2   = w_val1;
        nxt_least1 = entry_idx;
        nxt_val1   = bus.rd_data;
      end else if (w_found == 2'd1 || bus.rd_data < w_val2) begin
        nxt_least2 = entry_idx;
        nxt_val2   = bus.rd_data;
      end
      if (w_found != 2'd2) nxt_found = w_found + 2'd1;
    end
  end

  always_comb begin
    nxt_sum = '0;
    if (nxt_found == 2'd2) nxt_sum = {1'b0, nxt_val1} + {1'b0, nxt_val2};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      last_addr   <= '0;
      w_least1    <= '1;
      w_least2    <= '1;
      w_val1      <= '1;
      w_val2      <= '1;
      w_found     <= '0;
      bus.rd_req  <= 1'b0;
      bus.rd_addr <= '0;
      bus.least1  <= '1;
      bus.least2  <= '1;
      bus.val1    <= '1;
      bus.val2    <= '1;
      bus.sum     <= '0;
      bus.found   <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            w_least1    <= '1;
            w_least2    <= '1;
            w_val1      <= '1;
            w_val2      <= '1;
            w_found     <= '0;
            addr        <= '0;
            last_addr   <= AW'(LEAF_N - 1) + AW'(eff_limit);
            bus.rd_addr <= '0;
            bus.rd_req  <= 1'b1;
            bus.busy    <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          bus.rd_req <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (bus.rd_valid) begin
            w_least1 <= nxt_least1;
            w_least2 <= nxt_least2;
            w_val1   <= nxt_val1;
            w_val2   <= nxt_val2;
            w_found  <= nxt_found;
            if (addr == last_addr) begin
              bus.least1 <= nxt_least1;
              bus.least2 <= nxt_least2;
              bus.val1   <= nxt_val1;
              bus.val2   <= nxt_val2;
              bus.sum    <= nxt_sum;
              bus.found  <= nxt_found;
              bus.done   <= 1'b1;
              bus.busy   <= 1'b0;
              state      <= DONE;
            end else begin
              addr        <= addr + AW'(1);
              bus.rd_addr <= addr + AW'(1);
              bus.rd_req  <= 1'b1;
              state       <= REQ;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_t05_least_pair_finder.sv
// Randomized-latency bench for the least-pair finder against a
// sort-style reference of the two smallest nonzero weights.
`timescale 1ns/1ps
module tb_t05_least_pair_finder;
  localparam int CNT_W = 16, LEAF_N = 8, NODE_N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  t05_least_pair_finder_if #(.CNT_W(CNT_W), .LEAF_N(LEAF_N), .NODE_N(NODE_N)) bus ();
  t05_least_pair_finder #(.CNT_W(CNT_W), .LEAF_N(LEAF_N), .NODE_N(NODE_N)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0, n_err = 0;
  int read_cnt = 0, done_cnt = 0;
  logic [15:0] mem [16];
  logic [3:0]  prev_l1, prev_l2;
  logic [15:0] prev_v1, prev_v2;
  logic [16:0] prev_sum;
  logic [1:0]  prev_found;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // memory model: one response per request, 1..3 cycles later
  initial begin
    logic [3:0] a;
    int dly;
    bit pend;
    pend = 0; a = '0; dly = 0;
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    forever begin
      @(negedge clk);
      bus.rd_valid = 1'b0;
      bus.rd_data  = 16'($urandom);
      if (rst) pend = 0;
      else begin
        if (pend) begin
          if (dly == 1) begin
            bus.rd_valid = 1'b1;
            bus.rd_data  = mem[a];
            pend = 0;
          end else dly--;
        end
        if (bus.rd_req === 1'b1) begin
          a = bus.rd_addr;
          dly = $urandom_range(1, 3);
          pend = 1;
          read_cnt++;
        end
      end
    end
  end

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  // Entry order is leaves then nodes; with LEAF_N=8 the encoded index of
  // scan position i is simply i.
  task automatic model(input int lim, output logic [3:0] l1, output logic [3:0] l2,
                       output logic [15:0] v1, output logic [15:0] v2,
                       output logic [16:0] s, output logic [1:0] f, output int nreads);
    int vals[$];
    int idx[$];
    int eff;
    eff = (lim > NODE_N) ? NODE_N : lim;
    nreads = LEAF_N + eff;
    for (int i = 0; i < nreads; i++)
      if (mem[i] != 0) begin
        vals.push_back(int'(mem[i]));
        idx.push_back(i);
      end
    f = (vals.size() >= 2) ? 2'd2 : 2'(vals.size());
    l1 = 4'hF; l2 = 4'hF; v1 = 16'hFFFF; v2 = 16'hFFFF;
    for (int pass = 0; pass < 2; pass++) begin
      if (vals.size() > 0) begin
        int k;
        k = 0;
        for (int j = 1; j < vals.size(); j++) if (vals[j] < vals[k]) k = j;
        if (pass == 0) begin l1 = 4'(idx[k]); v1 = 16'(vals[k]); end
        else begin l2 = 4'(idx[k]); v2 = 16'(vals[k]); end
        vals.delete(k);
        idx.delete(k);
      end
    end
    s = (f == 2'd2) ? ({1'b0, v1} + {1'b0, v2}) : 17'd0;
  endtask

  task automatic run_scan(input int lim, input bit poke);
    logic [3:0] e_l1, e_l2;
    logic [15:0] e_v1, e_v2;
    logic [16:0] e_sum;
    logic [1:0] e_f;
    int nreads, cyc;
    model(lim, e_l1, e_l2, e_v1, e_v2, e_sum, e_f, nreads);
    bus.node_limit = 3'(lim);
    read_cnt = 0;
    done_cnt = 0;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    chk("busy_during_scan", bus.busy, 1);
    chk("hold_least1", bus.least1, prev_l1);
    chk("hold_val2", bus.val2, prev_v2);
    chk("hold_sum", bus.sum, prev_sum);
    if (poke) begin
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
    end
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", bus.done, 1);
    chk("least1", bus.least1, e_l1);
    chk("least2", bus.least2, e_l2);
    chk("val1", bus.val1, e_v1);
    chk("val2", bus.val2, e_v2);
    chk("sum", bus.sum, e_sum);
    chk("found", bus.found, e_f);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("read_count", read_cnt, nreads);
    chk("busy_after", bus.busy, 0);
    chk("held_val1", bus.val1, e_v1);
    prev_l1 = e_l1; prev_l2 = e_l2; prev_v1 = e_v1; prev_v2 = e_v2;
    prev_sum = e_sum; prev_found = e_f;
  endtask

  task automatic load_021();
    mem = '{default: 16'd0};
    mem[1] = 5; mem[2] = 3; mem[4] = 9; mem[5] = 3;
  endtask

  task automatic set_prev_reset();
    prev_l1 = 4'hF; prev_l2 = 4'hF; prev_v1 = 16'hFFFF; prev_v2 = 16'hFFFF;
    prev_sum = '0; prev_found = '0;
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0;
    bus.node_limit = '0;
    mem = '{default: 16'd0};
    set_prev_reset();
    #12;
    chk("rst_rd_req", bus.rd_req, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_least1", bus.least1, 4'hF);
    chk("rst_least2", bus.least2, 4'hF);
    chk("rst_val1", bus.val1, 16'hFFFF);
    chk("rst_val2", bus.val2, 16'hFFFF);
    chk("rst_sum", bus.sum, 0);
    chk("rst_found", bus.found, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    load_021();
    run_scan(0, 0);

    mem = '{default: 16'd0};
    mem[0] = 4; mem[7] = 7; mem[8] = 2;
    run_scan(1, 0);

    mem = '{default: 16'd0};
    mem[3] = 11;
    run_scan(0, 0);

    mem = '{default: 16'd0};
    run_scan(6, 0);

    mem = '{default: 16'd0};
    mem[1] = 16'hFFFF; mem[4] = 16'hFFFE;
    run_scan(0, 0);
    chk("sum_carry", bus.sum, 17'h1FFFD);

    // abort a scan during its 5th read, then rerun the same data
    load_021();
    bus.node_limit = '0;
    read_cnt = 0;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    cyc = 0;
    while (read_cnt < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached_read5", read_cnt, 5);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_rd_req", bus.rd_req, 0);
    chk("abort_found", bus.found, 0);
    chk("abort_val1", bus.val1, 16'hFFFF);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    set_prev_reset();
    repeat (5) @(negedge clk);
    run_scan(0, 1);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 12; i++) begin
        if ($urandom_range(0, 3) == 0) mem[i] = 16'd0;
        else if ($urandom_range(0, 7) == 0) mem[i] = 16'hFFFF - 16'($urandom_range(0, 2));
        else mem[i] = 16'($urandom_range(1, 20));
      end
      run_scan($urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
